// File: rtl/cla_pkg.sv
// Shared types and constants for the sequential carry-lookahead subtractor.
package cla_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned slice_count(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/cla_slice4.sv
// Combinational 4-bit generate/propagate carry-lookahead adder slice.
module cla_slice4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);
    assign cout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin_i);

    assign sum_o = p ^ c;

endmodule

// File: rtl/cla_seq_subtractor.sv
// Multi-cycle a - b - bin, one 4-bit lookahead slice per clock, valid/ready on both sides.
// Optional zero-result flag enabled by defining CLA_SEQ_ZERO_FLAG_EN.
module cla_seq_subtractor
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
`ifdef CLA_SEQ_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int unsigned NSLICE = slice_count(WIDTH);
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    generate
        if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
            $fatal(1, "cla_seq_subtractor: WIDTH must be a multiple of 4 and at least 4");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             carry_q, carry_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic             accept_c;
    logic             last_c;
    logic [3:0]       slice_a;
    logic [3:0]       slice_nb;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    assign accept_c = in_valid && in_ready_q;
    assign last_c   = (idx_q == LAST_IDX);

    // Operand slice selected by the current index
    always_comb begin : p_slice_mux
        slice_a  = '0;
        slice_nb = '0;
        for (int unsigned i = 0; i < NSLICE; i++) begin
            if (idx_q == IDX_W'(i)) begin
                slice_a  = a_q[i*SLICE_W +: SLICE_W];
                slice_nb = nb_q[i*SLICE_W +: SLICE_W];
            end
        end
    end

    cla_slice4 u_slice (
        .a_i    (slice_a),
        .b_i    (slice_nb),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            nb_q        <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef CLA_SEQ_ZERO_FLAG_EN
            zero_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            nb_q        <= nb_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef CLA_SEQ_ZERO_FLAG_EN
            zero_q      <= zero_d;
`endif
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)  state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Subtraction runs as a + ~b + ~bin; borrow-out is the inverted final carry
    always_comb begin : p_outputs
        a_d         = a_q;
        nb_d        = nb_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        diff_d      = diff_q;
        bout_d      = bout_q;
        ovf_d       = ovf_q;
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
`ifdef CLA_SEQ_ZERO_FLAG_EN
        zero_d      = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    idx_d   = '0;
`ifdef CLA_SEQ_ZERO_FLAG_EN
                    zero_d  = 1'b1;
`endif
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < NSLICE; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        diff_d[i*SLICE_W +: SLICE_W] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                idx_d   = idx_q + IDX_W'(1);
`ifdef CLA_SEQ_ZERO_FLAG_EN
                zero_d  = zero_q & (slice_sum == 4'd0);
`endif
                if (last_c) begin
                    bout_d = ~slice_cout;
                    ovf_d  = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (slice_sum[3] ^ a_q[WIDTH-1]);
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_cla_seq_subtractor.sv
// Directed and random bench for cla_seq_subtractor (WIDTH=16) with an arithmetic reference model.
module tb_cla_seq_subtractor;

    localparam int unsigned W = 16;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
`ifdef CLA_SEQ_ZERO_FLAG_EN
    logic         zero;
`endif

    cla_seq_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
`ifdef CLA_SEQ_ZERO_FLAG_EN
        .ovf       (ovf),
        .zero      (zero)
`else
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         bo;
        logic         ov;
        logic         z;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference: plain integer subtraction, borrow and signed range check
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
        exp_t       e;
        logic [W:0] r;
        int         sx, sy, sd;
        r    = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
        e.d  = r[W-1:0];
        e.bo = r[W];
        sx   = int'($signed(x));
        sy   = int'($signed(y));
        sd   = sx - sy - int'(bi);
        e.ov = (sd > 32767) || (sd < -32768);
        e.z  = (e.d == '0);
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic compare();
        if (rst) begin
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_diff", 32'(diff), 32'd0);
            chk("rst_bout", 32'(bout), 32'd0);
            chk("rst_ovf", 32'(ovf), 32'd0);
        end else if (out_valid) begin
            chk("hs_overlap", 32'(in_ready), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got out_valid=1 want no pending result at %0t", $time);
            end else begin
                chk("diff", 32'(diff), 32'(exp_q[0].d));
                chk("bout", 32'(bout), 32'(exp_q[0].bo));
                chk("ovf", 32'(ovf), 32'(exp_q[0].ov));
`ifdef CLA_SEQ_ZERO_FLAG_EN
                chk("zero", 32'(zero), 32'(exp_q[0].z));
`endif
            end
        end
    endtask

    // One clock: compare at negedge, sample handshakes, advance past posedge
    task automatic step();
        logic         acc, pop;
        logic [W-1:0] sa, sb;
        logic         sbin;
        exp_t         t;
        @(negedge clk);
        compare();
        acc  = in_valid && in_ready && !rst;
        pop  = out_valid && out_ready && !rst;
        sa   = a;
        sb   = b;
        sbin = bin;
        @(posedge clk);
        #1;
        if (acc) exp_q.push_back(model(sa, sb, sbin));
        if (pop && exp_q.size() > 0) t = exp_q.pop_front();
    endtask

    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xbin,
                         input int stall, input bit lit,
                         input logic [W-1:0] ed, input logic ebo, input logic eov);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        a         = xa;
        b         = xb;
        bin       = xbin;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_valid  = 1'b0;
        a         = W'($urandom);
        b         = W'($urandom);
        bin       = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'd4);
        if (lit) begin
            chk("lit_diff", 32'(diff), 32'(ed));
            chk("lit_bout", 32'(bout), 32'(ebo));
            chk("lit_ovf", 32'(ovf), 32'(eov));
`ifdef CLA_SEQ_ZERO_FLAG_EN
            chk("lit_zero", 32'(zero), 32'(ed == '0));
`endif
        end
        repeat (stall) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("release_out_valid", 32'(out_valid), 32'd0);
        chk("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        do_op(16'h0003, 16'h0002, 1'b0, 0, 1'b1, 16'h0001, 1'b0, 1'b0);
        do_op(16'h0002, 16'h0003, 1'b0, 1, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        do_op(16'h8000, 16'h0001, 1'b0, 0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
        do_op(16'h000F, 16'h0002, 1'b1, 2, 1'b1, 16'h000C, 1'b0, 1'b0);
        do_op(16'h0000, 16'h0000, 1'b1, 0, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b1, 16'h8000, 1'b1, 1'b1);

        // Backpressure with an ignored second request
        a = 16'h1234; b = 16'h0234; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        a = 16'hAAAA; b = 16'h5555;
        for (int i = 0; i < 12 && !out_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_diff", 32'(diff), 32'h1000);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        chk("bp_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset two cycles into RUN discards the pending result
        a = 16'h5555; b = 16'h1111; bin = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrun_rst_valid", 32'(out_valid), 32'd0);
        chk("midrun_rst_diff", 32'(diff), 32'd0);
        exp_q.delete();
        step();
        step();
        rst = 1'b0;
        step();
        chk("after_rst_in_ready", 32'(in_ready), 32'd1);
        chk("after_rst_valid", 32'(out_valid), 32'd0);
        do_op(16'h00FF, 16'h00FF, 1'b0, 0, 1'b1, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            do_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                  1'b0, '0, 1'b0, 1'b0);
        end
        step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
